// File: rtl/mc_control.sv
// Multi-cycle main controller for the MIPS-subset CPU: decodes IR, sequences
// IF/ID/EXE/MEM/WB, and drives the ALU and datapath write strobes.
module mc_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] OP,
    input  logic [5:0] Func,
    input  logic       Zero,
    input  logic       Overflow,
    output logic [2:0] ALUctr,
    output logic       ALUSrcB,
    output logic       ExtOp,
    output logic       PCWr,
    output logic [1:0] NPCsel,
    output logic       IRWr,
    output logic       MemWr,
    output logic       RegWr,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       Illegal,
    output logic [3:0] State
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 3;
    localparam int unsigned ST_W  = 4;

    localparam logic [OP_W-1:0] OP_R     = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [OP_W-1:0] FN_ADD  = 6'b100000;
    localparam logic [OP_W-1:0] FN_ADDU = 6'b100001;
    localparam logic [OP_W-1:0] FN_SUB  = 6'b100010;
    localparam logic [OP_W-1:0] FN_SUBU = 6'b100011;
    localparam logic [OP_W-1:0] FN_OR   = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT  = 6'b101010;
    localparam logic [OP_W-1:0] FN_SLTU = 6'b101011;

    localparam logic [ALU_W-1:0] ALU_ADDU = 3'b000;
    localparam logic [ALU_W-1:0] ALU_ADD  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_OR   = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUBU = 3'b100;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'b101;
    localparam logic [ALU_W-1:0] ALU_SLTU = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT  = 3'b111;

    typedef enum logic [ST_W-1:0] {
        S_RST   = 4'd0,
        S_IF    = 4'd1,
        S_ID    = 4'd2,
        S_EXE_R = 4'd3,
        S_EXE_I = 4'd4,
        S_MA    = 4'd5,
        S_MR    = 4'd6,
        S_MW    = 4'd7,
        S_WB_R  = 4'd8,
        S_WB_I  = 4'd9,
        S_WB_L  = 4'd10,
        S_BR    = 4'd11,
        S_JMP   = 4'd12
    } state_t;

    state_t           state_q, state_d;
    logic [ALU_W-1:0] aluctr_q, aluctr_d;
    logic [1:0]       npcsel_q, npcsel_d;
    logic             alusrcb_q, alusrcb_d;
    logic             extop_q, extop_d;
    logic             pcwr_q, pcwr_d;
    logic             irwr_q, irwr_d;
    logic             memwr_q, memwr_d;
    logic             regwr_q, regwr_d;
    logic             regdst_q, regdst_d;
    logic             memtoreg_q, memtoreg_d;
    logic             ov_q, ov_d;
    logic [ALU_W-1:0] alu_r;
    logic             r_ok;
    logic             op_ok;

    // R-type funct decode
    always_comb begin
        alu_r = ALU_ADDU;
        r_ok  = 1'b1;
        case (Func)
            FN_ADD:  alu_r = ALU_ADD;
            FN_ADDU: alu_r = ALU_ADDU;
            FN_SUB:  alu_r = ALU_SUB;
            FN_SUBU: alu_r = ALU_SUBU;
            FN_OR:   alu_r = ALU_OR;
            FN_SLT:  alu_r = ALU_SLT;
            FN_SLTU: alu_r = ALU_SLTU;
            default: r_ok  = 1'b0;
        endcase
    end

    always_comb begin
        op_ok = 1'b0;
        case (OP)
            OP_R:                                        op_ok = r_ok;
            OP_ADDIU, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J: op_ok = 1'b1;
            default:                                     op_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_RST:   state_d = S_IF;
            S_IF:    state_d = S_ID;
            S_ID: begin
                state_d = S_IF;
                if (op_ok) begin
                    case (OP)
                        OP_R:             state_d = S_EXE_R;
                        OP_ADDIU, OP_ORI: state_d = S_EXE_I;
                        OP_LW, OP_SW:     state_d = S_MA;
                        OP_BEQ:           state_d = S_BR;
                        OP_J:             state_d = S_JMP;
                        default:          state_d = S_IF;
                    endcase
                end
            end
            S_EXE_R: state_d = S_WB_R;
            S_EXE_I: state_d = S_WB_I;
            S_MA:    state_d = (OP == OP_LW) ? S_MR : S_MW;
            S_MR:    state_d = S_WB_L;
            default: state_d = S_IF;
        endcase
    end

    // Output registers are loaded with the decode of the state being entered,
    // so they change on the same edge as State.
    always_comb begin
        aluctr_d   = ALU_ADDU;
        npcsel_d   = 2'b00;
        alusrcb_d  = 1'b0;
        extop_d    = 1'b0;
        pcwr_d     = 1'b0;
        irwr_d     = 1'b0;
        memwr_d    = 1'b0;
        regwr_d    = 1'b0;
        regdst_d   = 1'b0;
        memtoreg_d = 1'b0;
        case (state_d)
            S_IF: begin
                irwr_d = 1'b1;
                pcwr_d = 1'b1;
            end
            S_EXE_R: aluctr_d = alu_r;
            S_EXE_I: begin
                alusrcb_d = 1'b1;
                aluctr_d  = (OP == OP_ORI) ? ALU_OR : ALU_ADDU;
                extop_d   = (OP != OP_ORI);
            end
            S_MA: begin
                alusrcb_d = 1'b1;
                extop_d   = 1'b1;
            end
            S_MW:    memwr_d = 1'b1;
            S_WB_R: begin
                regwr_d  = 1'b1;
                regdst_d = 1'b1;
            end
            S_WB_I:  regwr_d = 1'b1;
            S_WB_L: begin
                regwr_d    = 1'b1;
                memtoreg_d = 1'b1;
            end
            S_BR: begin
                aluctr_d = ALU_SUBU;
                npcsel_d = 2'b01;
            end
            S_JMP: begin
                pcwr_d   = 1'b1;
                npcsel_d = 2'b10;
            end
            default: ;
        endcase
    end

    // Signed overflow only matters for add/sub; captured at the end of EXE_R.
    assign ov_d = (state_q == S_EXE_R) && Overflow
                  && ((aluctr_q == ALU_ADD) || (aluctr_q == ALU_SUB));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_RST;
            aluctr_q   <= '0;
            npcsel_q   <= '0;
            alusrcb_q  <= 1'b0;
            extop_q    <= 1'b0;
            pcwr_q     <= 1'b0;
            irwr_q     <= 1'b0;
            memwr_q    <= 1'b0;
            regwr_q    <= 1'b0;
            regdst_q   <= 1'b0;
            memtoreg_q <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            aluctr_q   <= aluctr_d;
            npcsel_q   <= npcsel_d;
            alusrcb_q  <= alusrcb_d;
            extop_q    <= extop_d;
            pcwr_q     <= pcwr_d;
            irwr_q     <= irwr_d;
            memwr_q    <= memwr_d;
            regwr_q    <= regwr_d;
            regdst_q   <= regdst_d;
            memtoreg_q <= memtoreg_d;
            ov_q       <= ov_d;
        end
    end

    // Zero and the IR fields are only valid in the same cycle, hence the
    // combinational terms on PCWr (BR) and Illegal (ID).
    assign PCWr     = pcwr_q | ((state_q == S_BR) & Zero);
    assign Illegal  = (state_q == S_ID) & ~op_ok;
    assign RegWr    = regwr_q & ~ov_q;
    assign ALUctr   = aluctr_q;
    assign NPCsel   = npcsel_q;
    assign ALUSrcB  = alusrcb_q;
    assign ExtOp    = extop_q;
    assign IRWr     = irwr_q;
    assign MemWr    = memwr_q;
    assign RegDst   = regdst_q;
    assign MemtoReg = memtoreg_q;
    assign State    = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: instruction table expanded into per-cycle expected
// outputs, pushed to a scoreboard at drive time and checked at the falling edge.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] OP, Func;
    logic       Zero, Overflow;
    logic [2:0] ALUctr;
    logic       ALUSrcB, ExtOp, PCWr, IRWr, MemWr, RegWr, RegDst, MemtoReg, Illegal;
    logic [1:0] NPCsel;
    logic [3:0] State;

    mc_control dut (
        .clk(clk), .rst_n(rst_n), .OP(OP), .Func(Func), .Zero(Zero),
        .Overflow(Overflow), .ALUctr(ALUctr), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp),
        .PCWr(PCWr), .NPCsel(NPCsel), .IRWr(IRWr), .MemWr(MemWr), .RegWr(RegWr),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] alu;
        logic       srcb;
        logic       ext;
        logic       pcwr;
        logic [1:0] npc;
        logic       irwr;
        logic       memwr;
        logic       regwr;
        logic       regdst;
        logic       m2r;
        logic       ill;
    } out_t;

    typedef enum int {C_R, C_I, C_LW, C_SW, C_BR, C_J, C_ILL} cls_t;

    typedef struct {
        string      nm;
        logic [5:0] op;
        logic [5:0] fn;
        logic       zero;
        logic       ovf;
        cls_t       cls;
        logic [2:0] alu;
        logic       ext;
        logic       wbw;
    } vec_t;

    typedef struct {
        out_t  exp;
        string nm;
        int    cyc;
    } sb_t;

    sb_t  sbq[$];
    sb_t  cur;
    out_t got;
    int   n_chk  = 0;
    int   n_pass = 0;
    vec_t tbl[20];

    function automatic vec_t mk(string nm, logic [5:0] op, logic [5:0] fn, logic z,
                                logic ov, cls_t c, logic [2:0] alu, logic ext, logic wbw);
        vec_t v;
        v.nm = nm; v.op = op; v.fn = fn; v.zero = z; v.ovf = ov;
        v.cls = c; v.alu = alu; v.ext = ext; v.wbw = wbw;
        return v;
    endfunction

    function automatic int ncyc(cls_t c);
        case (c)
            C_LW:       return 5;
            C_BR, C_J:  return 3;
            C_ILL:      return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic out_t exp_out(vec_t v, int k);
        out_t o;
        o = '0;
        if (k == 0) begin
            o.st = 4'd1; o.irwr = 1'b1; o.pcwr = 1'b1;
        end else if (k == 1) begin
            o.st = 4'd2; o.ill = (v.cls == C_ILL);
        end else begin
            case (v.cls)
                C_R: if (k == 2) begin o.st = 4'd3; o.alu = v.alu; end
                     else begin o.st = 4'd8; o.regwr = v.wbw; o.regdst = 1'b1; end
                C_I: if (k == 2) begin o.st = 4'd4; o.alu = v.alu; o.srcb = 1'b1; o.ext = v.ext; end
                     else begin o.st = 4'd9; o.regwr = 1'b1; end
                C_LW, C_SW: begin
                    if (k == 2) begin o.st = 4'd5; o.srcb = 1'b1; o.ext = 1'b1; end
                    else if (v.cls == C_SW) begin o.st = 4'd7; o.memwr = 1'b1; end
                    else if (k == 3) o.st = 4'd6;
                    else begin o.st = 4'd10; o.regwr = 1'b1; o.m2r = 1'b1; end
                end
                C_BR: begin o.st = 4'd11; o.alu = 3'b100; o.npc = 2'b01; o.pcwr = v.zero; end
                C_J:  begin o.st = 4'd12; o.pcwr = 1'b1; o.npc = 2'b10; end
                default: ;
            endcase
        end
        return o;
    endfunction

    task automatic drive_cycle(logic [5:0] op, logic [5:0] fn, logic z, logic ov,
                               out_t e, string nm, int k);
        sb_t s;
        @(posedge clk);
        #1;
        OP = op; Func = fn; Zero = z; Overflow = ov;
        s.exp = e; s.nm = nm; s.cyc = k;
        sbq.push_back(s);
    endtask

    // abort_at >= 0 pulls rst_n low during that cycle of the instruction
    task automatic run_instr(vec_t v, int abort_at);
        logic [5:0] op, fn;
        logic       z, ov;
        for (int k = 0; k < ncyc(v.cls); k++) begin
            op = (k == 0) ? 6'($urandom) : v.op;
            fn = (k == 0) ? 6'($urandom) : v.fn;
            z  = (v.cls == C_BR && k == 2) ? v.zero : 1'($urandom);
            ov = (k == 2) ? v.ovf : 1'($urandom);
            drive_cycle(op, fn, z, ov, exp_out(v, k), v.nm, k);
            if (k == abort_at) begin
                rst_n = 1'b0;
                drive_cycle(6'($urandom), 6'($urandom), 1'b1, 1'b1, '0, "abort_rst", 0);
                rst_n = 1'b1;
                return;
            end
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            cur = sbq.pop_front();
            got = {State, ALUctr, ALUSrcB, ExtOp, PCWr, NPCsel, IRWr, MemWr,
                   RegWr, RegDst, MemtoReg, Illegal};
            n_chk++;
            if (got === cur.exp) n_pass++;
            else $display("FAIL %s cyc%0d: got st=%0d alu=%b srcb=%b ext=%b pcwr=%b npc=%b irwr=%b memwr=%b regwr=%b regdst=%b m2r=%b ill=%b, exp st=%0d alu=%b srcb=%b ext=%b pcwr=%b npc=%b irwr=%b memwr=%b regwr=%b regdst=%b m2r=%b ill=%b",
                          cur.nm, cur.cyc,
                          got.st, got.alu, got.srcb, got.ext, got.pcwr, got.npc, got.irwr,
                          got.memwr, got.regwr, got.regdst, got.m2r, got.ill,
                          cur.exp.st, cur.exp.alu, cur.exp.srcb, cur.exp.ext, cur.exp.pcwr,
                          cur.exp.npc, cur.exp.irwr, cur.exp.memwr, cur.exp.regwr,
                          cur.exp.regdst, cur.exp.m2r, cur.exp.ill);
        end
    end

    initial begin
        tbl[0]  = mk("add",      6'b000000, 6'b100000, 1'b0, 1'b0, C_R,   3'b001, 1'b0, 1'b1);
        tbl[1]  = mk("addu",     6'b000000, 6'b100001, 1'b0, 1'b0, C_R,   3'b000, 1'b0, 1'b1);
        tbl[2]  = mk("sub",      6'b000000, 6'b100010, 1'b0, 1'b0, C_R,   3'b101, 1'b0, 1'b1);
        tbl[3]  = mk("subu",     6'b000000, 6'b100011, 1'b0, 1'b0, C_R,   3'b100, 1'b0, 1'b1);
        tbl[4]  = mk("or",       6'b000000, 6'b100101, 1'b0, 1'b0, C_R,   3'b010, 1'b0, 1'b1);
        tbl[5]  = mk("slt",      6'b000000, 6'b101010, 1'b0, 1'b0, C_R,   3'b111, 1'b0, 1'b1);
        tbl[6]  = mk("sltu",     6'b000000, 6'b101011, 1'b0, 1'b0, C_R,   3'b110, 1'b0, 1'b1);
        tbl[7]  = mk("add_ov",   6'b000000, 6'b100000, 1'b0, 1'b1, C_R,   3'b001, 1'b0, 1'b0);
        tbl[8]  = mk("addu_ov",  6'b000000, 6'b100001, 1'b0, 1'b1, C_R,   3'b000, 1'b0, 1'b1);
        tbl[9]  = mk("sub_ov",   6'b000000, 6'b100010, 1'b0, 1'b1, C_R,   3'b101, 1'b0, 1'b0);
        tbl[10] = mk("sltu_ov",  6'b000000, 6'b101011, 1'b0, 1'b1, C_R,   3'b110, 1'b0, 1'b1);
        tbl[11] = mk("addiu",    6'b001001, 6'b100000, 1'b0, 1'b0, C_I,   3'b000, 1'b1, 1'b1);
        tbl[12] = mk("ori",      6'b001101, 6'b100010, 1'b0, 1'b0, C_I,   3'b010, 1'b0, 1'b1);
        tbl[13] = mk("lw",       6'b100011, 6'b000000, 1'b0, 1'b0, C_LW,  3'b000, 1'b1, 1'b1);
        tbl[14] = mk("sw",       6'b101011, 6'b000000, 1'b0, 1'b0, C_SW,  3'b000, 1'b1, 1'b0);
        tbl[15] = mk("beq_tk",   6'b000100, 6'b000000, 1'b1, 1'b0, C_BR,  3'b100, 1'b0, 1'b0);
        tbl[16] = mk("beq_nt",   6'b000100, 6'b000000, 1'b0, 1'b0, C_BR,  3'b100, 1'b0, 1'b0);
        tbl[17] = mk("j",        6'b000010, 6'b000000, 1'b0, 1'b0, C_J,   3'b000, 1'b0, 1'b0);
        tbl[18] = mk("ill_op",   6'b111111, 6'b100000, 1'b0, 1'b0, C_ILL, 3'b000, 1'b0, 1'b0);
        tbl[19] = mk("ill_fn",   6'b000000, 6'b000000, 1'b0, 1'b0, C_ILL, 3'b000, 1'b0, 1'b0);

        rst_n = 1'b0; OP = '0; Func = '0; Zero = 1'b0; Overflow = 1'b0;

        // Reset held for three edges with random inputs; outputs must stay 0
        for (int i = 0; i < 3; i++)
            drive_cycle(6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), '0, "reset", i);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) run_instr(tbl[i], -1);

        // sw aborted by reset during MW, then recovery with a plain addu
        run_instr(tbl[14], 3);
        run_instr(tbl[1], -1);
        // beq aborted during BR with Zero=1, then a j
        run_instr(tbl[15], 2);
        run_instr(tbl[17], -1);

        @(negedge clk);
        #1;
        n_chk++;
        if (sbq.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending entries, exp 0", sbq.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
